// File: rtl/output_buffer_acc_pkg.sv
// Shared types and helpers for the output matrix buffer.
// Latency: none, combinational definitions only.
// Backpressure: not applicable.
package output_buffer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } obuf_state_e;

    // Widest element the saturating adder supports; callers sign-extend into it.
    localparam int unsigned SAT_MAXW = 32;

    function automatic logic signed [SAT_MAXW-1:0] sat_add(
        input logic signed [SAT_MAXW-1:0] a,
        input logic signed [SAT_MAXW-1:0] b,
        input int unsigned                w
    );
        logic signed [SAT_MAXW:0] s;
        logic signed [SAT_MAXW:0] one;
        logic signed [SAT_MAXW:0] hi;
        logic signed [SAT_MAXW:0] lo;
        one = {{SAT_MAXW{1'b0}}, 1'b1};
        s   = {a[SAT_MAXW-1], a} + {b[SAT_MAXW-1], b};
        hi  = (one << (w - 1)) - one;
        lo  = -(one << (w - 1));
        if (s > hi) begin
            return hi[SAT_MAXW-1:0];
        end else if (s < lo) begin
            return lo[SAT_MAXW-1:0];
        end
        return s[SAT_MAXW-1:0];
    endfunction

endpackage

// File: rtl/output_buffer_acc_if.sv
// Compute-side write/accumulate, AXI-side beat read and clear-control bundle.
// Latency: wires only.
// Backpressure: b_ready gates port B; port A and clr_start are never stalled.
interface output_buffer_acc_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned PACK       = 2
);
    localparam int unsigned PW = $clog2(PACK);

    logic                           clr_start;
    logic                           clr_busy;
    logic                           b_valid;
    logic                           b_ready;
    logic                           b_acc;
    logic [ADDR_WIDTH-1:0]          b_addr;
    logic [DATA_WIDTH-1:0]          b_din;
    logic                           a_req;
    logic [ADDR_WIDTH-PW-1:0]       a_addr;
    logic                           a_valid;
    logic [DATA_WIDTH*PACK-1:0]     a_dout;

    modport master (
        output clr_start, b_valid, b_acc, b_addr, b_din, a_req, a_addr,
        input  clr_busy, b_ready, a_valid, a_dout
    );

    modport slave (
        input  clr_start, b_valid, b_acc, b_addr, b_din, a_req, a_addr,
        output clr_busy, b_ready, a_valid, a_dout
    );

endinterface

// File: rtl/output_buffer_acc_ram.sv
// Banked element store: one write port, one element read, one full-beat read.
// Latency: reads are combinational, write lands on the clock edge.
// Backpressure: none, every port serviced each cycle.
module obuf_ram #(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  ADDR_WIDTH = 12,
    parameter int unsigned  PACK       = 2,
    localparam int unsigned PW         = $clog2(PACK)
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [ADDR_WIDTH-1:0]        i_waddr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    input  logic [ADDR_WIDTH-1:0]        i_raddr,
    output logic [DATA_WIDTH-1:0]        o_rdata,
    input  logic [ADDR_WIDTH-PW-1:0]     i_beat_addr,
    output logic [DATA_WIDTH*PACK-1:0]   o_beat_data
);
    localparam int unsigned PWS = (PW == 0) ? 1 : PW;
    localparam int unsigned BAW = ADDR_WIDTH - PW;

    logic [PWS-1:0]        w_wbank;
    logic [PWS-1:0]        w_rbank;
    logic [BAW-1:0]        w_wrow;
    logic [BAW-1:0]        w_rrow;
    logic [DATA_WIDTH-1:0] w_rd_lane [PACK];

    assign w_wrow = i_waddr[ADDR_WIDTH-1:PW];
    assign w_rrow = i_raddr[ADDR_WIDTH-1:PW];

    generate
        if (PW == 0) begin : g_one_bank
            assign w_wbank = '0;
            assign w_rbank = '0;
        end else begin : g_multi_bank
            assign w_wbank = i_waddr[PWS-1:0];
            assign w_rbank = i_raddr[PWS-1:0];
        end
    endgenerate

    // Lane k of a beat lives in bank k, so a beat read touches every bank once.
    for (genvar k = 0; k < PACK; k++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [2**BAW];

        always_ff @(posedge clk) begin
            if (i_we && (w_wbank == PWS'(k))) begin
                r_mem[w_wrow] <= i_wdata;
            end
        end

        assign w_rd_lane[k] = r_mem[w_rrow];
        assign o_beat_data[(PACK-k)*DATA_WIDTH-1 -: DATA_WIDTH] = r_mem[i_beat_addr];
    end

    assign o_rdata = w_rd_lane[w_rbank];

endmodule

// File: rtl/output_buffer_acc.sv
// Output matrix buffer: port-B write/saturating accumulate, port-A packed beat read, clear sweep.
// Latency: port-B result readable 2 cycles after accept; port-A data 1 cycle after a_req.
// Backpressure: b_ready drops for the whole clear sweep; port A never stalls.
module output_buffer_acc
    import output_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned PACK       = 2,
    parameter bit          ACC_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    output_buffer_acc_if.slave bus
);
    obuf_state_e                  r_state;
    logic [ADDR_WIDTH-1:0]        r_clr_cnt;
    logic                         r_clr_busy;
    logic                         r_s2_vld;
    logic                         r_s2_acc;
    logic [ADDR_WIDTH-1:0]        r_s2_addr;
    logic signed [DATA_WIDTH-1:0] r_s2_din;
    logic signed [DATA_WIDTH-1:0] r_s2_old;
    logic                         r_a_vld;
    logic [DATA_WIDTH*PACK-1:0]   r_a_dout;

    logic                         w_b_fire;
    logic [DATA_WIDTH-1:0]        w_ram_rd;
    logic [DATA_WIDTH*PACK-1:0]   w_beat;
    logic signed [SAT_MAXW-1:0]   w_sum;
    logic                         w_unused_sum;
    logic signed [DATA_WIDTH-1:0] w_s2_res;
    logic signed [DATA_WIDTH-1:0] w_s1_old;
    logic                         w_we;
    logic [ADDR_WIDTH-1:0]        w_waddr;
    logic [DATA_WIDTH-1:0]        w_wdata;

    assign bus.clr_busy = r_clr_busy;
    assign bus.b_ready  = !r_clr_busy;
    assign bus.a_valid  = r_a_vld;
    assign bus.a_dout   = r_a_dout;

    assign w_b_fire     = bus.b_valid && !r_clr_busy;
    assign w_sum        = sat_add(SAT_MAXW'(r_s2_old), SAT_MAXW'(r_s2_din), DATA_WIDTH);
    assign w_unused_sum = ^w_sum[SAT_MAXW-1:DATA_WIDTH];
    assign w_s2_res     = r_s2_acc ? w_sum[DATA_WIDTH-1:0] : r_s2_din;

    // The RAM still holds the pre-S2 value, so a same-address op must take the S2 result.
    assign w_s1_old = (r_s2_vld && (r_s2_addr == bus.b_addr)) ? w_s2_res : w_ram_rd;

    // No port-B op is accepted while clearing; one left in S2 at sweep start is zeroed later anyway.
    always_comb begin
        w_we    = r_s2_vld;
        w_waddr = r_s2_addr;
        w_wdata = w_s2_res;
        if (r_clr_busy) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = '0;
        end
    end

    obuf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PACK       (PACK)
    ) u_ram (
        .clk         (clk),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_raddr     (bus.b_addr),
        .o_rdata     (w_ram_rd),
        .i_beat_addr (bus.a_addr),
        .o_beat_data (w_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_clr_cnt  <= '0;
            r_clr_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clr_start) begin
                        r_state    <= CLEAR;
                        r_clr_cnt  <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
                    if (r_clr_cnt == '1) begin
                        r_state    <= IDLE;
                        r_clr_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_acc  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_din  <= '0;
            r_s2_old  <= '0;
        end else begin
            r_s2_vld <= w_b_fire;
            if (w_b_fire) begin
                r_s2_acc  <= ACC_EN && bus.b_acc;
                r_s2_addr <= bus.b_addr;
                r_s2_din  <= bus.b_din;
                r_s2_old  <= w_s1_old;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_vld  <= 1'b0;
            r_a_dout <= '0;
        end else begin
            r_a_vld <= bus.a_req;
            if (bus.a_req) begin
                r_a_dout <= w_beat;
            end
        end
    end

endmodule

// File: tb/tb_output_buffer_acc.sv
// Bench for output_buffer_acc: directed corner cases plus randomized traffic against an array model.
module tb_output_buffer_acc;
    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int PACK  = 2;
    localparam int BAW   = AW - $clog2(PACK);
    localparam int DEPTH = 1 << AW;
    localparam int NBEAT = DEPTH / PACK;

    typedef struct {
        int cyc;
        int addr;
        int val;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // mdl_now: value after every accepted op; mdl_vis: what a port-A read can see.
    int                 mdl_now [DEPTH];
    int                 mdl_vis [DEPTH];
    wr_t                pend [$];
    logic [DW*PACK-1:0] last_beat = '0;

    always #5 clk = ~clk;

    output_buffer_acc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACK(PACK)) bus ();

    output_buffer_acc #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PACK       (PACK),
        .ACC_EN     (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        logic signed [DW-1:0] t;
        t = DW'(v);
        return int'(t);
    endfunction

    function automatic int sat(input int v);
        int hi;
        int lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // An op accepted in cycle t is seen by reads issued in cycle t+2 or later.
    task automatic commit_upto(input int c);
        while (pend.size() > 0 && pend[0].cyc + 2 <= c) begin
            mdl_vis[pend[0].addr] = pend[0].val;
            void'(pend.pop_front());
        end
    endtask

    function automatic logic [DW*PACK-1:0] exp_beat(input int a);
        logic [DW*PACK-1:0] r;
        r = '0;
        for (int k = 0; k < PACK; k++) begin
            r[(PACK-k)*DW-1 -: DW] = DW'(mdl_vis[PACK*a+k]);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input bit bv, input bit acc, input int addr, input int din,
                        input bit rq, input int ra, input string tag);
        logic [DW*PACK-1:0] e;
        e = '0;
        bus.b_valid = bv;
        bus.b_acc   = acc;
        bus.b_addr  = AW'(addr);
        bus.b_din   = DW'(din);
        bus.a_req   = rq;
        bus.a_addr  = BAW'(ra);
        if (bv) begin
            int v;
            check_val({tag, "_rdy"}, 64'(bus.b_ready), 64'(1));
            v = acc ? sat(mdl_now[addr] + sx(din)) : sx(din);
            mdl_now[addr] = v;
            pend.push_back('{cyc: cyc, addr: addr, val: v});
        end
        if (rq) begin
            commit_upto(cyc);
            e = exp_beat(ra);
        end
        tick();
        check_val({tag, "_vld"}, 64'(bus.a_valid), 64'(rq));
        if (rq) last_beat = e;
        check_val({tag, "_dat"}, 64'(bus.a_dout), 64'(last_beat));
        bus.b_valid = 1'b0;
        bus.a_req   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, "idle");
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.clr_start = 1'b0;
        bus.b_valid   = 1'b0;
        bus.b_acc     = 1'b0;
        bus.b_addr    = '0;
        bus.b_din     = '0;
        bus.a_req     = 1'b0;
        bus.a_addr    = '0;

        #12;
        check_val("rst_vld",  64'(bus.a_valid),  64'(0));
        check_val("rst_dout", 64'(bus.a_dout),   64'(0));
        check_val("rst_busy", 64'(bus.clr_busy), 64'(0));
        check_val("rst_rdy",  64'(bus.b_ready),  64'(1));
        rst_n = 1'b1;
        tick();

        // Clear sweep with a write held against it; a second clr_start mid-sweep must be ignored.
        bus.clr_start = 1'b1;
        check_val("clr_busy_pre", 64'(bus.clr_busy), 64'(0));
        tick();
        bus.clr_start = 1'b0;
        check_val("clr_busy_on", 64'(bus.clr_busy), 64'(1));
        check_val("clr_rdy_off", 64'(bus.b_ready),  64'(0));
        bus.b_valid = 1'b1;
        bus.b_acc   = 1'b0;
        bus.b_addr  = AW'(9);
        bus.b_din   = 16'h0055;
        n = 0;
        while (bus.clr_busy === 1'b1 && n < 5000) begin
            bus.clr_start = (n == 100);
            n++;
            tick();
        end
        bus.clr_start = 1'b0;
        check_val("clr_len", 64'(n), 64'(DEPTH));
        foreach (mdl_now[i]) begin
            mdl_now[i] = 0;
            mdl_vis[i] = 0;
        end
        pend.delete();
        step(1'b1, 1'b0, 9, 'h55, 1'b0, 0, "clr_held");
        for (int a = 0; a < NBEAT; a++) step(1'b0, 1'b0, 0, 0, 1'b1, a, "clr_rd");

        // Packed two-element beat.
        step(1'b1, 1'b0, 4, 'hABCD, 1'b0, 0, "t2_w4");
        step(1'b1, 1'b0, 5, 'h1234, 1'b0, 0, "t2_w5");
        idle(1);
        step(1'b0, 1'b0, 0, 0, 1'b1, 2, "t2_rd");
        check_val("t2_lit", 64'(bus.a_dout), 64'(32'hABCD1234));

        // Back-to-back accumulate through the forwarding path.
        step(1'b1, 1'b0, 7, 100, 1'b0, 0, "t3_w");
        step(1'b1, 1'b1, 7, 50,  1'b0, 0, "t3_a1");
        step(1'b1, 1'b1, 7, 25,  1'b0, 0, "t3_a2");
        idle(1);
        step(1'b0, 1'b0, 0, 0, 1'b1, 3, "t3_rd");
        check_val("t3_lit", 64'(bus.a_dout), 64'(32'h000000AF));

        // Saturation at both rails.
        step(1'b1, 1'b0, 10, 'h7FF0, 1'b0, 0, "t4_wp");
        step(1'b1, 1'b1, 10, 'h0020, 1'b0, 0, "t4_ap");
        step(1'b1, 1'b0, 11, 'h8000, 1'b0, 0, "t4_wn");
        step(1'b1, 1'b1, 11, 'hFFFF, 1'b0, 0, "t4_an");
        idle(1);
        step(1'b0, 1'b0, 0, 0, 1'b1, 5, "t4_rd");
        check_val("t4_lit", 64'(bus.a_dout), 64'(32'h7FFF8000));

        // Read colliding with the S2 write returns old data, next cycle returns new.
        step(1'b1, 1'b0, 20, 'h1111, 1'b0, 0, "t6_w0");
        idle(2);
        step(1'b1, 1'b0, 20, 'h2222, 1'b0, 0, "t6_w1");
        step(1'b0, 1'b0, 0, 0, 1'b1, 10, "t6_old");
        check_val("t6_old_lit", 64'(bus.a_dout), 64'(32'h11110000));
        step(1'b0, 1'b0, 0, 0, 1'b1, 10, "t6_new");
        check_val("t6_new_lit", 64'(bus.a_dout), 64'(32'h22220000));

        // Reset while an accumulate sits in the pipe: it must be dropped.
        step(1'b1, 1'b0, 100, 'h1111, 1'b0, 0, "t1_w");
        idle(2);
        step(1'b1, 1'b1, 100, 1, 1'b1, 50, "t1_acc");
        bus.b_valid = 1'b1;
        bus.b_acc   = 1'b1;
        bus.b_addr  = AW'(100);
        bus.b_din   = 16'h0001;
        bus.a_req   = 1'b1;
        bus.a_addr  = BAW'(50);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst2_vld",  64'(bus.a_valid),  64'(0));
        check_val("rst2_dout", 64'(bus.a_dout),   64'(0));
        check_val("rst2_busy", 64'(bus.clr_busy), 64'(0));
        commit_upto(cyc);
        mdl_now = mdl_vis;
        pend.delete();
        last_beat   = '0;
        bus.b_valid = 1'b0;
        bus.b_acc   = 1'b0;
        bus.a_req   = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        check_val("rst2_rdy", 64'(bus.b_ready), 64'(1));
        tick();
        step(1'b0, 1'b0, 0, 0, 1'b1, 50, "t1_rd");
        check_val("t1_lit", 64'(bus.a_dout), 64'(32'h11110000));

        // Random traffic on a small window so hazards and collisions are frequent.
        for (int i = 0; i < 3000; i++) begin
            int din;
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       din = $urandom_range(0, 64) - 32;
                1:       din = 'h7F00 + $urandom_range(0, 255);
                2:       din = 'h8000 + $urandom_range(0, 255);
                default: din = $urandom_range(0, 65535);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), din,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), "rnd");
        end
        idle(2);
        for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 0, 0, 1'b1, a, "rnd_final");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
